// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    SCRUB = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detector: the instruction in ID reads the
// destination of a load currently in EX.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memr,
  input  logic       ex_regw,
  output logic       load_use
);

  // Hit when a register-writing load targets a source that ID actually reads
  always_comb begin
    load_use = ex_memr && ex_regw && (ex_rd != REG_X0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: data-memory handshake FSM, load-use
// bubbles, EX redirect flushes, post-reset scrub, stall counting and
// memory timeout detection.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memr,
  input  logic             ex_regw,
  input  logic             ex_redirect,
  input  logic             mem_op,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              timeout;
  logic              adv;
  logic              lu_bubble;

  hazard_unit u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_memr    (ex_memr),
    .ex_regw    (ex_regw),
    .load_use   (load_use)
  );

  // Advance qualifier: the MEM instruction is done (or abandoned) this cycle
  always_comb begin
    timeout = (state == WAIT) && !dmem_ack && (wait_cnt == WAIT_LAST);
    adv     = ((state == IDLE) && !mem_op) ||
              ((state == WAIT) && (dmem_ack || timeout));
  end

  // Output priority: scrub, memory freeze, redirect, load-use bubble, run
  always_comb begin
    pc_en       = 1'b1;
    en_if_id    = 1'b1;
    en_id_ex    = 1'b1;
    en_ex_mem   = 1'b1;
    en_mem_wb   = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    lu_bubble   = 1'b0;
    if (state == SCRUB) begin
      pc_en       = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (!adv) begin
      pc_en     = 1'b0;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      en_mem_wb = 1'b0;
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      en_if_id    = 1'b0;
      flush_id_ex = 1'b1;
      lu_bubble   = 1'b1;
    end
  end

  // Memory handshake FSM with registered request and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SCRUB;
      wait_cnt    <= '0;
      dmem_req    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        SCRUB: state <= IDLE;
        IDLE: begin
          if (mem_op) begin
            state    <= WAIT;
            wait_cnt <= '0;
            dmem_req <= 1'b1;
          end
        end
        WAIT: begin
          if (dmem_ack || timeout) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            if (timeout) err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= SCRUB;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of frozen-writeback and bubble cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((!en_mem_wb || lu_bubble) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       ex_memr = 1'b0, ex_regw = 1'b0, ex_redirect = 1'b0;
  logic       mem_op = 1'b0, dmem_ack = 1'b0;
  logic       dmem_req, pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic       flush_if_id, flush_id_ex, err_timeout;
  logic [7:0] stall_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [6:0] V_SCRUB  = 7'b0111111;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_REDIR  = 7'b1111111;
  localparam logic [6:0] V_LU     = 7'b0011101;
  localparam logic [6:0] V_RUN    = 7'b1111100;

  pipeline_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_memr     (ex_memr),
    .ex_regw     (ex_regw),
    .ex_redirect (ex_redirect),
    .mem_op      (mem_op),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .pc_en       (pc_en),
    .en_if_id    (en_if_id),
    .en_id_ex    (en_id_ex),
    .en_ex_mem   (en_ex_mem),
    .en_mem_wb   (en_mem_wb),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .err_timeout (err_timeout),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish (got running, want done)");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    check_eq(tag, {57'd0, pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                   flush_if_id, flush_id_ex}, {57'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_lu();
    ex_memr = 0; ex_regw = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  initial begin
    // Reset held
    #2;
    chk_out("rst_outs", V_SCRUB);
    check_eq("rst_req", dmem_req, 0);
    check_eq("rst_cnt", stall_cnt, 0);
    check_eq("rst_err", err_timeout, 0);
    @(posedge clk);
    #2 rst = 1;
    #1 chk_out("scrub_c0", V_SCRUB);
    // Idle; a stray ack must be ignored
    tick(); dmem_ack = 1;
    #1 chk_out("idle_c1", V_RUN);
    tick(); dmem_ack = 0;
    #1 check_eq("idle_ack_ignored_req", dmem_req, 0);
    check_eq("idle_cnt", stall_cnt, 0);

    // Memory op, ack on 3rd WAIT cycle
    mem_op = 1;
    #1 chk_out("mem_t", V_FREEZE);
    check_eq("mem_t_req", dmem_req, 0);
    tick(); #1 chk_out("mem_w1", V_FREEZE);
    check_eq("mem_w1_req", dmem_req, 1);
    tick(); #1 chk_out("mem_w2", V_FREEZE);
    tick(); dmem_ack = 1;
    #1 chk_out("mem_w3_ack", V_RUN);
    check_eq("mem_w3_req", dmem_req, 1);
    tick(); mem_op = 0; dmem_ack = 0;
    #1 check_eq("mem_req_drop", dmem_req, 0);
    chk_out("mem_after", V_RUN);
    check_eq("mem_cnt", stall_cnt, 3);

    // Redirect during freeze: held off until the ack cycle
    mem_op = 1; ex_redirect = 1;
    #1 chk_out("frz_redir_t", V_FREEZE);
    tick(); #1 chk_out("frz_redir_w1", V_FREEZE);
    tick(); dmem_ack = 1;
    #1 chk_out("frz_redir_ack", V_REDIR);
    // Back-to-back memory op: new request, no ack reuse
    tick(); ex_redirect = 0; dmem_ack = 0;
    #1 chk_out("b2b_t", V_FREEZE);
    check_eq("b2b_t_req", dmem_req, 0);
    check_eq("b2b_cnt", stall_cnt, 5);
    tick(); dmem_ack = 1;
    #1 chk_out("b2b_ack", V_RUN);
    check_eq("b2b_req", dmem_req, 1);
    tick(); mem_op = 0; dmem_ack = 0;
    #1 check_eq("b2b_cnt2", stall_cnt, 6);

    // Load-use via rs2
    ex_memr = 1; ex_regw = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    #1 chk_out("lu_rs2", V_LU);
    tick(); clr_lu();
    #1 chk_out("lu_rs2_after", V_RUN);
    check_eq("lu_rs2_cnt", stall_cnt, 7);
    // Load-use via rs1
    ex_memr = 1; ex_regw = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
    #1 chk_out("lu_rs1", V_LU);
    tick(); id_use_rs1 = 0;
    #1 chk_out("lu_rs1_unused", V_RUN);
    check_eq("lu_rs1_cnt", stall_cnt, 8);
    // x0 destination never hazards
    ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
    #1 chk_out("lu_x0", V_RUN);
    // Non-writing load never hazards
    ex_rd = 5; id_rs2 = 5; ex_regw = 0;
    #1 chk_out("lu_noregw", V_RUN);
    // Redirect suppresses load-use
    ex_regw = 1; ex_redirect = 1;
    #1 chk_out("redir_lu", V_REDIR);
    tick(); ex_redirect = 0; clr_lu();
    #1 check_eq("redir_lu_cnt", stall_cnt, 8);

    // Timeout: MAX_WAIT=4, no ack
    mem_op = 1;
    #1 chk_out("to_t", V_FREEZE);
    tick(); #1 chk_out("to_w1", V_FREEZE);
    tick(); tick();
    #1 chk_out("to_w3", V_FREEZE);
    tick(); #1 chk_out("to_w4_adv", V_RUN);
    check_eq("to_w4_err", err_timeout, 0);
    check_eq("to_w4_req", dmem_req, 1);
    tick(); mem_op = 0;
    #1 check_eq("to_err", err_timeout, 1);
    check_eq("to_req", dmem_req, 0);
    check_eq("to_cnt", stall_cnt, 12);
    tick(); #1 check_eq("to_err_sticky", err_timeout, 1);

    // Saturation: repeated timeouts, 4 stalls per 5 cycles
    mem_op = 1;
    for (int i = 0; i < 400; i++) tick();
    mem_op = 0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("sat_cnt", stall_cnt, 8'hFF);
    check_eq("sat_err", err_timeout, 1);

    // Reset during WAIT
    mem_op = 1;
    tick();
    #1 check_eq("rw_req_pre", dmem_req, 1);
    rst = 0;
    #1 check_eq("rw_req", dmem_req, 0);
    check_eq("rw_cnt", stall_cnt, 0);
    check_eq("rw_err", err_timeout, 0);
    chk_out("rw_outs", V_SCRUB);
    mem_op = 0;
    tick(); rst = 1;
    #1 chk_out("rw_scrub", V_SCRUB);
    tick(); #1 chk_out("rw_run", V_RUN);
    check_eq("rw_cnt_after", stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
